// File: rtl/maxsonar_pkg.sv
// maxsonar_pkg: shared FSM states and default constants for the MaxSonar PW decoder
package maxsonar_pkg;
    typedef enum logic [1:0] {ARM, WAIT_RISE, MEASURE, PUBLISH} state_t;
    localparam int CLKS_PER_INCH_DEF = 14700;
    localparam int TIMEOUT_CYCLES_DEF = 10_000_000;
    localparam logic [7:0] INCH_MAX = 8'd255;
endpackage

// File: rtl/maxsonar_pwm_decoder_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    // shift the raw input through two flops to resolve metastability
    always_ff @(posedge clk or negedge reset)
        if (!reset) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/maxsonar_pwm_decoder.sv
// maxsonar_pwm_decoder: converts MaxSonar PW high time to inches with a loss-of-sensor watchdog
module maxsonar_pwm_decoder
    import maxsonar_pkg::*;
#(
    parameter int CLKS_PER_INCH = CLKS_PER_INCH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pw,
    output logic [7:0] distance,
    output logic       new_dist,
    output logic       overrange,
    output logic       sensor_lost
);
    localparam int PW = $clog2(CLKS_PER_INCH + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_INCH - 1);
    localparam logic [23:0] TIMEOUT = 24'(TIMEOUT_CYCLES);
    logic pw_s, pw_d, rise, fall, wrap, sat;
    logic [PW-1:0] presc;
    logic [7:0] inch;
    logic [1:0] arm_cnt;
    logic [23:0] wd;
    state_t state;
    sync_2ff u_sync (.clk(clk), .reset(reset), .d(pw), .q(pw_s));
    assign rise = pw_s & ~pw_d;
    assign fall = ~pw_s & pw_d;
    assign wrap = presc == PRESC_LAST;
    // previous synchronized level for edge detection
    always_ff @(posedge clk or negedge reset)
        if (!reset) pw_d <= 1'b0;
        else pw_d <= pw_s;
    // measurement FSM; ARM waits for the synchronizer to settle so a pulse in flight at reset is skipped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARM;
            arm_cnt <= '0;
            presc <= '0;
            inch <= '0;
            sat <= 1'b0;
            distance <= '0;
            new_dist <= 1'b0;
            overrange <= 1'b0;
        end else begin
            new_dist <= 1'b0;
            case (state)
                ARM: begin
                    if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
                    else if (!pw_s) state <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        presc <= '0;
                        inch <= '0;
                        sat <= 1'b0;
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    presc <= wrap ? '0 : presc + PW'(1);
                    if (wrap) begin
                        if (inch == INCH_MAX) sat <= 1'b1;
                        else inch <= inch + 8'd1;
                    end
                    if (fall) state <= PUBLISH;
                end
                PUBLISH: begin
                    distance <= inch;
                    overrange <= sat;
                    new_dist <= 1'b1;
                    state <= WAIT_RISE;
                end
                default: state <= ARM;
            endcase
        end
    end
    // watchdog: any rising edge restarts it; reaching the limit flags the sensor as lost
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd <= '0;
            sensor_lost <= 1'b0;
        end else if (rise) begin
            wd <= '0;
            sensor_lost <= 1'b0;
        end else begin
            if (wd != '1) wd <= wd + 24'd1;
            if (wd >= TIMEOUT) sensor_lost <= 1'b1;
        end
    end
endmodule

// File: tb/tb_maxsonar_pwm_decoder.sv
// tb_maxsonar_pwm_decoder: directed pulse-width vectors against hand-computed inch values
module tb_maxsonar_pwm_decoder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pw = 1'b0;
    logic [7:0] distance;
    logic new_dist, overrange, sensor_lost;
    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    int doubles = 0;
    int cap_d = 0;
    int cap_o = 0;
    int s0;
    logic prev_nd = 1'b0;

    maxsonar_pwm_decoder #(.CLKS_PER_INCH(10), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk),
        .reset(reset),
        .pw(pw),
        .distance(distance),
        .new_dist(new_dist),
        .overrange(overrange),
        .sensor_lost(sensor_lost)
    );

    always #5 clk = ~clk;

    // record each strobe and catch back-to-back strobes
    always @(negedge clk) begin
        if (new_dist) begin
            strobes++;
            cap_d = int'(distance);
            cap_o = int'(overrange);
        end
        if (new_dist && prev_nd) doubles++;
        prev_nd = new_dist;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int n);
        @(negedge clk);
        pw = 1'b1;
        cycles(n);
        pw = 1'b0;
        cycles(20);
    endtask

    task automatic measure(input string tag, input int n, input int exp_d, input int exp_o);
        int s;
        s = strobes;
        pulse(n);
        check({tag, "_strobes"}, strobes - s, 1);
        check({tag, "_dist"}, cap_d, exp_d);
        check({tag, "_ovr"}, cap_o, exp_o);
    endtask

    initial begin
        cycles(5);
        check("rst_dist", distance, 0);
        check("rst_nd", new_dist, 0);
        check("rst_ovr", overrange, 0);
        check("rst_lost", sensor_lost, 0);
        reset = 1'b1;
        cycles(10);
        measure("p420", 420, 42, 0);
        measure("p9", 9, 0, 0);
        measure("p10", 10, 1, 0);
        measure("p19", 19, 1, 0);
        measure("p3000", 3000, 255, 1);
        measure("p100", 100, 10, 0);
        measure("p2550", 2550, 255, 0);
        // pw already high across reset release
        pw = 1'b1;
        reset = 1'b0;
        cycles(5);
        reset = 1'b1;
        s0 = strobes;
        cycles(30);
        pw = 1'b0;
        cycles(20);
        check("inflight_nostrobe", strobes - s0, 0);
        measure("p50", 50, 5, 0);
        // reset in the middle of a pulse
        s0 = strobes;
        pw = 1'b1;
        cycles(200);
        reset = 1'b0;
        #1;
        check("midrst_dist", distance, 0);
        check("midrst_nd", new_dist, 0);
        check("midrst_ovr", overrange, 0);
        check("midrst_lost", sensor_lost, 0);
        pw = 1'b0;
        cycles(5);
        reset = 1'b1;
        cycles(20);
        check("midrst_nostrobe", strobes - s0, 0);
        cycles(880);
        check("lost_early", sensor_lost, 0);
        cycles(200);
        check("lost_set", sensor_lost, 1);
        check("lost_nostrobe", strobes - s0, 0);
        check("lost_dist", distance, 0);
        pw = 1'b1;
        cycles(5);
        check("lost_clear", sensor_lost, 0);
        pw = 1'b0;
        cycles(20);
        check("final_strobes", strobes - s0, 1);
        check("final_dist", cap_d, 0);
        check("no_double", doubles, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
